// File: rtl/sinegen_ctrl.sv
// Phase-accumulator sequencer for the dual-port sine ROM, with registered sample pairs.
// Define SINEGEN_SWEEP_EN to enable the increment sweep (RUN -> HOLD at incr_end).
module sinegen_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int ACC_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [ACC_WIDTH-1:0]     incr_start_i,
  input  logic [ACC_WIDTH-1:0]     incr_end_i,
  input  logic [ACC_WIDTH-1:0]     sweep_step_i,
  input  logic [ADDRESS_WIDTH-1:0] offset_i,
  output logic [ADDRESS_WIDTH-1:0] addr1_o,
  output logic [ADDRESS_WIDTH-1:0] addr2_o,
  input  logic [DATA_WIDTH-1:0]    dout1_i,
  input  logic [DATA_WIDTH-1:0]    dout2_i,
  output logic [DATA_WIDTH-1:0]    sample1_o,
  output logic [DATA_WIDTH-1:0]    sample2_o,
  output logic                     valid_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  state_e                   state_q;
  logic [ACC_WIDTH-1:0]     phase_q;
  logic [ACC_WIDTH-1:0]     incr_q;
  logic [ADDRESS_WIDTH-1:0] addr2_q;
  logic                     issue_q;
  logic                     valid_q;
  logic [DATA_WIDTH-1:0]    sample1_q;
  logic [DATA_WIDTH-1:0]    sample2_q;
  logic                     done_q;
  logic                     busy_q;

  logic [ACC_WIDTH-1:0]     phase_d;
  logic [ADDRESS_WIDTH-1:0] addr2_d;

  // Port 2 address is registered alongside the phase so both ROM ports see matching pairs.
  always_comb begin
    phase_d = phase_q + incr_q;
    addr2_d = phase_d[ACC_WIDTH-1 -: ADDRESS_WIDTH] + offset_i;
  end

`ifdef SINEGEN_SWEEP_EN
  logic [ACC_WIDTH:0] sweepSum_d;

  always_comb begin
    sweepSum_d = {1'b0, incr_q} + {1'b0, sweep_step_i};
  end
`else
  logic unusedSweepInputs;

  assign unusedSweepInputs = ^{incr_end_i, sweep_step_i};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      incr_q    <= '0;
      addr2_q   <= '0;
      issue_q   <= 1'b0;
      valid_q   <= 1'b0;
      sample1_q <= '0;
      sample2_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // ROM reads the current addresses this cycle; data is captured one cycle later.
      issue_q <= en_i && (state_q != IDLE);
      valid_q <= issue_q;
      if (issue_q) begin
        sample1_q <= dout1_i;
        sample2_q <= dout2_i;
      end
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            phase_q <= '0;
            incr_q  <= incr_start_i;
            addr2_q <= offset_i;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN, HOLD: begin
          if (stop_i) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (en_i) begin
            phase_q <= phase_d;
            addr2_q <= addr2_d;
`ifdef SINEGEN_SWEEP_EN
            if (state_q == RUN) begin
              if (sweepSum_d >= {1'b0, incr_end_i}) begin
                incr_q  <= incr_end_i;
                state_q <= HOLD;
              end else begin
                incr_q <= sweepSum_d[ACC_WIDTH-1:0];
              end
            end
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr1_o   = phase_q[ACC_WIDTH-1 -: ADDRESS_WIDTH];
  assign addr2_o   = addr2_q;
  assign sample1_o = sample1_q;
  assign sample2_o = sample2_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: doc/sinegen_ctrl.md
# sinegen_ctrl

Sequencer for the dual-port sine lookup ROM (one-cycle registered read, two address/data ports). It holds a phase accumulator with an optionally sweeping frequency increment. It drives ROM port 1 with the accumulator phase and port 2 with the same phase plus a programmable offset. It returns aligned, registered sample pairs with a valid strobe to the downstream DAC/plot stage.

## Interface
- ADDRESS_WIDTH, 8: ROM address width; must equal the ROM's ADDRESS_WIDTH.
- DATA_WIDTH, 8: ROM data width.
- ACC_WIDTH, 16: phase accumulator width, ≥ ADDRESS_WIDTH.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample strobe; phase advances only on en cycles while running.
- start  input  1  begin generation (accepted in IDLE only).
- stop  input  1  end generation (accepted in RUN/HOLD only).
- incr_start  input  ACC_WIDTH  initial phase increment.
- incr_end  input  ACC_WIDTH  final sweep increment.
- sweep_step  input  ACC_WIDTH  added to increment per en cycle in RUN.
- offset  input  ADDRESS_WIDTH  port-2 phase offset in ROM entries.
- addr1, addr2  output  ADDRESS_WIDTH each  to ROM addr1/addr2.
- dout1, dout2  input  DATA_WIDTH each  from ROM dout1/dout2.
- sample1, sample2  output  DATA_WIDTH each  registered samples.
- valid  output  1  sample1/sample2 hold a new pair this cycle.
- busy  output  1  high in RUN or HOLD.
- done  output  1  one-cycle pulse on accepted stop.

## Operation
- States: IDLE, RUN (sweeping), HOLD (increment fixed at incr_end).
- Reset: state IDLE, phase 0, incr 0, pipeline cleared. Outputs: addr1 0, addr2 0 (offset ignored while in reset), sample1/sample2 0, valid 0, busy 0, done 0.
- IDLE + start: phase ← 0, incr ← incr_start, go to RUN. stop in IDLE is ignored; start with stop in IDLE starts.
- RUN/HOLD + stop: go to IDLE, done = 1 for the next cycle, phase and incr hold. start is ignored; stop wins on coincidence.
- RUN, en=1, no stop: phase ← phase + incr, mod 2^ACC_WIDTH.
  - Compute s = incr + sweep_step at ACC_WIDTH+1 bits.
  - If s ≥ incr_end: incr ← incr_end, go to HOLD.
  - Otherwise incr ← s[ACC_WIDTH-1:0].
  - sweep_step = 0 with incr_start < incr_end stays in RUN indefinitely.
- HOLD, en=1: phase ← phase + incr; incr is unchanged.
- en=0: phase, incr and state are unchanged (stop is still accepted).
- Addresses:
  - addr1 = phase[ACC_WIDTH-1 -: ADDRESS_WIDTH], taken directly from the register, no comb logic after it.
  - addr2 = addr1 + offset, mod 2^ADDRESS_WIDTH (wraps, registered with phase).
  - offset changes take effect on the next phase update or start.
- Inputs incr_start, incr_end, sweep_step are sampled live; changes mid-sweep take effect on the next en cycle.

## Timing
- Issue: a cycle t with en=1 and state RUN/HOLD is an issue cycle. The current addr1/addr2 are read by the ROM at the end of t.
- Cycle t+1: ROM dout valid. The controller captures dout1/dout2 into sample1/sample2 at the end of t+1.
- Cycle t+2: valid = 1. Latency from en to valid is 2 cycles, via a 2-stage issue shift register. Sample pair i always matches address pair i.
- valid is high exactly once per issue cycle; continuous en gives continuous valid.
- sample1/sample2 hold their last values when valid = 0.
- Pending pairs are delivered after stop: up to 2 valid cycles may follow done.
- rst mid-operation clears the pipeline immediately; no valid after reset.
- First pair after start uses phase 0: addr1 = 0, addr2 = offset.
- busy rises the cycle after an accepted start and falls the cycle after an accepted stop.

## Configuration
- SINEGEN_SWEEP_EN defined: sweep logic, HOLD state and sweep_step/incr_end are active as above.
- Not defined:
  - incr ← incr_start on start and stays constant; HOLD is unreachable.
  - sweep_step and incr_end are ignored; ports stay present.
  - All other timing is identical.

## Test plan
- Bench ROM content: sinerom.mem, 256 entries; addr 0 = 0x80, addr 64 = 0xFF.
- Basic tone: incr_start=0x0100, sweep_step=0, offset=64, en=1, start at cycle 0 → addr1 = 0,1,2,… from cycle 1; first valid at cycle 3 with sample1=0x80, sample2=0xFF.
- Wrap: incr_start=0xFF00, offset=0xC0 → addr1 = 0x00,0xFF,0xFE,…; addr2 = addr1+0xC0 mod 256 (0xC0,0xBF,…); no glitch at the wrap.
- Sweep (macro on): incr_start=0x0100, incr_end=0x0400, sweep_step=0x0100 → incr 0x100,0x200,0x300, then 0x400 and HOLD on the 3rd en; phase = 0,0x100,0x300,0x600,0xA00,0xE00. Macro off: incr stays 0x0100.
- Gated en: en high every 4th cycle → exactly one valid per en pulse, each 2 cycles later; phase advances only on en cycles.
- Control edges:
  - stop in RUN → done 1 cycle; busy drops; up to 2 trailing valids.
  - start and stop together in IDLE → RUN.
  - start in RUN → ignored.
- Reset mid-run: rst at any cycle → next cycle addr 0, valid 0, busy 0, sample 0, state IDLE.
